// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction-fetch front end.
package ifetch_pkg;
    localparam int IFETCH_DEPTH   = 4;
    localparam int IFETCH_A_WIDTH = 8;
    localparam int IFETCH_I_WIDTH = 16;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head, occupancy count and a flush that beats push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the read side is qualified by empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q] <= push_data;
    end
endmodule

// File: rtl/ifetch.sv
// Fetch front end: issues req/gnt reads at pc, tracks in-flight reads, buffers in-order
// responses and hands {addr, instr} to decode; a redirect flushes and drops stale responses.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int A_WIDTH = IFETCH_A_WIDTH,
    parameter int I_WIDTH = IFETCH_I_WIDTH,
    parameter int DEPTH   = IFETCH_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] pc_addr,
    output logic               pc_advance,
    input  logic               redirect,
    output logic               mem_req,
    output logic [A_WIDTH-1:0] mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [I_WIDTH-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [I_WIDTH-1:0] instr,
    output logic [A_WIDTH-1:0] instr_addr
);
    localparam int CW = cnt_width(DEPTH);

    logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d;
    logic [CW-1:0] ibuf_cnt, tagq_cnt;
    logic [CW:0]   occ;
    logic          grant, ibuf_push, ibuf_pop;
    logic          ibuf_full, ibuf_empty, tagq_full, tagq_empty;
    logic [A_WIDTH-1:0]         tag_head;
    logic [A_WIDTH+I_WIDTH-1:0] ibuf_head;

    // Request gating uses registered counts only, so no path from decode or memory data.
    assign occ        = {1'b0, inflight_q} + {1'b0, ibuf_cnt};
    assign mem_req    = !rst && !redirect && (occ < (CW+1)'(DEPTH));
    assign mem_addr   = pc_addr;
    assign grant      = mem_req && mem_gnt;
    assign pc_advance = grant;

    assign ibuf_push  = mem_rvalid && !redirect && (drop_q == '0);
    assign ibuf_pop   = instr_valid && instr_ready && !redirect;

    assign instr_valid           = !ibuf_empty;
    assign {instr_addr, instr}   = ibuf_empty ? '0 : ibuf_head;

    always_comb begin
        inflight_d = inflight_q + CW'(grant) - CW'(mem_rvalid);
        drop_d     = drop_q;
        if (redirect)
            drop_d = inflight_q - CW'(mem_rvalid);
        else if (mem_rvalid && drop_q != '0)
            drop_d = drop_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(.WIDTH(A_WIDTH), .DEPTH(DEPTH)) u_tagq (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (mem_addr),
        .pop       (mem_rvalid),
        .flush     (1'b0),
        .head      (tag_head),
        .count     (tagq_cnt),
        .full      (tagq_full),
        .empty     (tagq_empty)
    );

    sync_fifo #(.WIDTH(A_WIDTH + I_WIDTH), .DEPTH(DEPTH)) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .push      (ibuf_push),
        .push_data ({tag_head, mem_rdata}),
        .pop       (ibuf_pop),
        .flush     (redirect),
        .head      (ibuf_head),
        .count     (ibuf_cnt),
        .full      (ibuf_full),
        .empty     (ibuf_empty)
    );

    a_no_ibuf_ovf:  assert property (@(posedge clk) disable iff (rst) !(ibuf_push && ibuf_full));
    a_no_tagq_ovf:  assert property (@(posedge clk) disable iff (rst) !(grant && tagq_full && !mem_rvalid));
    a_rsp_has_tag:  assert property (@(posedge clk) disable iff (rst) !(mem_rvalid && tagq_empty));
    a_tag_tracks:   assert property (@(posedge clk) disable iff (rst) tagq_cnt == inflight_q);
    a_drop_bounded: assert property (@(posedge clk) disable iff (rst) drop_q <= inflight_q);
endmodule
